pipe_hold_unit: RTL

Consumer side of the hazard unit's stall/flush signalling. It owns the PC register, the IF/ID instruction/PC+4 latch and the ID/EX control-field latch, and applies the three enables and PCSrc: hold, bubble insertion, or redirect-plus-flush. It sits between fetch and decode in the five-stage pipeline and tracks stall/flush episodes with a small state machine.

---
 rtl/pipe_hold_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipe_hold_unit.sv
// pipe_hold_unit: PC register, IF/ID latch and ID/EX control latch driven by
// the hazard unit's enables and PCSrc (hold, bubble, redirect-plus-flush).
// Optional macro PIPE_HOLD_PERF_EN adds stall_cycles/flush_events counters.
module pipe_hold_unit #(
  parameter int          CTRL_W       = 9,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          MAX_STALL    = 15,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in1,
  input  logic              en_in2,
  input  logic              en_in3,
  input  logic              PCSrc,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [1:0]        state,
  output logic              stall_err
`ifdef PIPE_HOLD_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIM  = 8'(MAX_STALL);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic              err_q, err_d;

  logic [31:0] pc_plus4;
  logic        stall;

  assign pc_plus4 = pc_q + 32'd4;
  assign stall    = !PCSrc && !(en_in1 && en_in2 && en_in3);

  // Next-state logic: redirect beats stall beats normal advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    if (PCSrc) begin
      pc_d        = branch_target;
      instr_d     = '0;
      pc4_d       = '0;
      ctrl_d      = '0;
      flush_cnt_d = FLUSH_INIT;
      stall_cnt_d = '0;
      state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (stall) begin
      if (en_in1) pc_d = pc_plus4;
      if (en_in2) begin
        // Slots still owed to a flush stay NOP even if IF/ID is written.
        instr_d = (state_q == ST_FLUSH && flush_cnt_q != '0) ? '0 : instr_in;
        pc4_d   = pc_plus4;
      end
      ctrl_d      = en_in3 ? ctrl_in : '0;
      stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
      if (stall_cnt_d >= STALL_LIM) err_d = 1'b1;
      // A stall inside a flush freezes the flush counter; FLUSH is kept.
      if (state_q != ST_FLUSH) state_d = ST_STALL;
    end else begin
      pc_d        = pc_plus4;
      instr_d     = instr_in;
      pc4_d       = pc_plus4;
      ctrl_d      = ctrl_in;
      stall_cnt_d = '0;
      case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q != '0) begin
            instr_d     = '0;
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_d == '0) state_d = ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and pipeline latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pc4_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign idex_ctrl  = ctrl_q;
  assign state      = state_q;
  assign stall_err  = err_q;

`ifdef PIPE_HOLD_PERF_EN
  logic [15:0] stall_cyc_q, flush_ev_q;

  // Saturating performance counters for stall cycles and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_ev_q  <= '0;
    end else begin
      if (stall && stall_cyc_q != 16'hFFFF) stall_cyc_q <= stall_cyc_q + 16'd1;
      if (PCSrc && flush_ev_q != 16'hFFFF)  flush_ev_q  <= flush_ev_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cyc_q;
  assign flush_events = flush_ev_q;
`endif

endmodule
